// File: rtl/conv_operand_loader.sv
// Serial operand loader: collects a 25-byte frame (16 image + 9 filter bytes),
// commits it atomically to parallel buses, pulses run, then blocks input for a busy window.
module conv_operand_loader #(
  parameter int DATA_W      = 8,
  parameter int BUSY_CYCLES = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic [16*DATA_W-1:0]  img_bus,
  output logic [9*DATA_W-1:0]   flt_bus,
  output logic                  run,
  output logic                  busy,
  output logic                  frame_err,
  output logic [1:0]            state
);

  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t                 cur_state, nxt_state;
  logic [4:0]             idx;
  logic [CNT_W-1:0]       busy_cnt;
  // The final byte goes straight to the bus at commit, so only 24 slots are shadowed.
  logic [24*DATA_W-1:0]   shadow;
  logic                   accept, at_end, good_end, bad_end;
  logic                   run_d, err_d;

  assign accept   = in_valid && in_ready;
  assign at_end   = (idx == 5'd24);
  assign good_end = accept && at_end && in_last;
  // A frame is malformed when in_last and the 25th position disagree.
  assign bad_end  = accept && (in_last ^ at_end);
  assign state    = cur_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= LOAD;
    else        cur_state <= nxt_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      LOAD:    if (good_end) nxt_state = FIRE;
      FIRE:    nxt_state = BUSY;
      BUSY:    if (busy_cnt == CNT_W'(1)) nxt_state = LOAD;
      default: nxt_state = LOAD;
    endcase
  end

  always_comb begin
    in_ready = (cur_state == LOAD);
    busy     = (cur_state == FIRE) || (cur_state == BUSY);
    run_d    = (cur_state == LOAD) && (nxt_state == FIRE);
    err_d    = bad_end;
  end

  // NOTE: shadow storage is reset along with everything else so a partial frame never leaks across reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      busy_cnt  <= '0;
      shadow    <= '0;
      img_bus   <= '0;
      flt_bus   <= '0;
      run       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      run       <= run_d;
      frame_err <= err_d;

      if (accept) begin
        if (in_last || at_end) idx <= '0;
        else                   idx <= idx + 5'd1;
        if (!in_last && !at_end)
          shadow[int'(idx)*DATA_W +: DATA_W] <= in_data;
      end

      if (good_end) begin
        img_bus <= shadow[16*DATA_W-1:0];
        flt_bus <= {in_data, shadow[24*DATA_W-1:16*DATA_W]};
      end

      if (cur_state == FIRE)      busy_cnt <= CNT_W'(BUSY_CYCLES);
      else if (cur_state == BUSY) busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

endmodule
